instr_encoder: RTL and testbench

Inverse of the pipeline controller/decoder. It takes decoded instruction fields (type one-hot, f3, f7, rs1, rs2, rd, immediate) and packs them into a 32-bit RV32I instruction word. Encoded words are streamed with a byte address to the instruction-memory loader, which the testbench and program-load path use to build imem images. Each request is checked for legality; an illegal request produces a NOP word and is counted.

---
 rtl/rv_isa_pkg.sv | 54 +++++
 rtl/instr_field_packer.sv | 80 ++++++++
 rtl/instr_encoder.sv | 105 ++++++++++
 tb/tb_instr_encoder.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_isa_pkg.sv
// ============================================================================
//  Module      : rv_isa_pkg
//  Description : RV32I encoding constants and types shared by the controller,
//                decoder and instruction encoder.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package rv_isa_pkg;

  localparam logic [6:0] c_OP_R     = 7'b0110011;
  localparam logic [6:0] c_OP_I_ALU = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
  localparam logic [6:0] c_OP_S     = 7'b0100011;
  localparam logic [6:0] c_OP_B     = 7'b1100011;
  localparam logic [6:0] c_OP_JAL   = 7'b1101111;
  localparam logic [6:0] c_OP_LUI   = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC = 7'b0010111;
  localparam logic [6:0] c_OP_JALR  = 7'b1100111;

  // Bit positions inside the one-hot instruction class vector
  localparam int c_T_R     = 8;
  localparam int c_T_I_ALU = 7;
  localparam int c_T_LOAD  = 6;
  localparam int c_T_S     = 5;
  localparam int c_T_B     = 4;
  localparam int c_T_JAL   = 3;
  localparam int c_T_LUI   = 2;
  localparam int c_T_AUIPC = 1;
  localparam int c_T_JALR  = 0;

  localparam logic [31:0] c_NOP_WORD = 32'h0000_0000;
  localparam logic [6:0]  c_F7_ZERO  = 7'h00;
  localparam logic [6:0]  c_F7_ALT   = 7'h20;

  typedef struct packed {
    logic [8:0]  itype;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
  } req_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ENC  = 2'd1,
    S_OUT  = 2'd2
  } enc_state_e;

endpackage

`default_nettype wire

// File: rtl/instr_field_packer.sv
// ============================================================================
//  Module      : instr_field_packer
//  Description : Packs a registered decoded request into an RV32I word and
//                flags illegal requests (word forced to NOP).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_field_packer
  import rv_isa_pkg::*;
(
  input  req_t        req,
  output logic [31:0] word,
  output logic        illegal
);

  logic        w_multi;
  logic        w_imm12_ok;
  logic        w_imm13_ok;
  logic        w_imm21_ok;
  logic        w_shift;
  logic [31:0] w_raw;
  logic        w_bad;

  assign w_multi    = |(req.itype & (req.itype - 9'd1));
  assign w_imm12_ok = (&req.imm[31:11]) | ~(|req.imm[31:11]);
  assign w_imm13_ok = (&req.imm[31:12]) | ~(|req.imm[31:12]);
  assign w_imm21_ok = (&req.imm[31:20]) | ~(|req.imm[31:20]);
  assign w_shift    = (req.f3 == 3'd1) || (req.f3 == 3'd5);

  always_comb begin
    w_raw = c_NOP_WORD;
    w_bad = 1'b0;
    if (w_multi) begin
      w_bad = 1'b1;
    end else if (req.itype[c_T_R]) begin
      w_raw = {req.f7, req.rs2, req.rs1, req.f3, req.rd, c_OP_R};
      w_bad = ((req.f7 != c_F7_ZERO) && (req.f7 != c_F7_ALT)) ||
              ((req.f7 == c_F7_ALT) && (req.f3 != 3'd0) && (req.f3 != 3'd5));
    end else if (req.itype[c_T_I_ALU]) begin
      if (w_shift) begin
        // Shift amount lives in the rs2 slot, f7 selects logical/arithmetic
        w_raw = {req.f7, req.imm[4:0], req.rs1, req.f3, req.rd, c_OP_I_ALU};
        w_bad = ((req.f3 == 3'd1) && (req.f7 != c_F7_ZERO)) ||
                ((req.f3 == 3'd5) && (req.f7 != c_F7_ZERO) && (req.f7 != c_F7_ALT));
      end else begin
        w_raw = {req.imm[11:0], req.rs1, req.f3, req.rd, c_OP_I_ALU};
        w_bad = !w_imm12_ok;
      end
    end else if (req.itype[c_T_LOAD]) begin
      w_raw = {req.imm[11:0], req.rs1, req.f3, req.rd, c_OP_LOAD};
      w_bad = !w_imm12_ok || (req.f3 == 3'd3) || (req.f3 >= 3'd6);
    end else if (req.itype[c_T_S]) begin
      w_raw = {req.imm[11:5], req.rs2, req.rs1, req.f3, req.imm[4:0], c_OP_S};
      w_bad = (req.f3 > 3'd2) || !w_imm12_ok;
    end else if (req.itype[c_T_B]) begin
      w_raw = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.f3,
               req.imm[4:1], req.imm[11], c_OP_B};
      w_bad = (req.f3 == 3'd2) || (req.f3 == 3'd3) || req.imm[0] || !w_imm13_ok;
    end else if (req.itype[c_T_JAL]) begin
      w_raw = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12], req.rd, c_OP_JAL};
      w_bad = req.imm[0] || !w_imm21_ok;
    end else if (req.itype[c_T_LUI]) begin
      w_raw = {req.imm[31:12], req.rd, c_OP_LUI};
      w_bad = |req.imm[11:0];
    end else if (req.itype[c_T_AUIPC]) begin
      w_raw = {req.imm[31:12], req.rd, c_OP_AUIPC};
      w_bad = |req.imm[11:0];
    end else if (req.itype[c_T_JALR]) begin
      w_raw = {req.imm[11:0], req.rs1, req.f3, req.rd, c_OP_JALR};
      w_bad = !w_imm12_ok || (req.f3 != 3'd0);
    end
  end

  assign word    = w_bad ? c_NOP_WORD : w_raw;
  assign illegal = w_bad;

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================================
//  Module      : instr_encoder
//  Description : Request -> RV32I word encoder streaming words with byte
//                addresses to the instruction-memory loader.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_encoder
  import rv_isa_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int ERR_W     = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [8:0]        in_type,
  input  logic [2:0]        in_f3,
  input  logic [6:0]        in_f7,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rd,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_illegal,
  output logic [ERR_W-1:0]  err_count
);

  localparam logic [ADDR_W-1:0] c_BASE = ADDR_W'(BASE_ADDR);

  enc_state_e        r_state;
  enc_state_e        w_state_next;
  req_t              r_req;
  logic [31:0]       w_word;
  logic              w_illegal;
  logic [31:0]       r_instr;
  logic              r_illegal;
  logic [ADDR_W-1:0] r_addr;
  logic [ERR_W-1:0]  r_err;

  instr_field_packer u_packer (
    .req     (r_req),
    .word    (w_word),
    .illegal (w_illegal)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = S_ENC;
      end
      S_ENC:  w_state_next = S_OUT;
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_req     <= '0;
      r_instr   <= c_NOP_WORD;
      r_illegal <= 1'b0;
      r_addr    <= c_BASE;
      r_err     <= '0;
    end else begin
      if (in_valid && in_ready) begin
        r_req <= '{itype: in_type, f3: in_f3, f7: in_f7, rs1: in_rs1,
                   rs2: in_rs2, rd: in_rd, imm: in_imm};
      end
      // Errors are counted when the word is formed, not when it is consumed
      if (r_state == S_ENC) begin
        r_instr   <= w_word;
        r_illegal <= w_illegal;
        if (w_illegal && !(&r_err)) r_err <= r_err + ERR_W'(1);
      end
      if (out_valid && out_ready) r_addr <= r_addr + ADDR_W'(4);
    end
  end

  assign out_instr   = r_instr;
  assign out_illegal = r_illegal;
  assign out_addr    = r_addr;
  assign err_count   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
//  Module      : tb_instr_encoder
//  Description : Self-checking bench for instr_encoder (ADDR_W=4 so address
//                wrap is reached quickly).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_encoder;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [8:0]  in_type = '0;
  logic [2:0]  in_f3 = '0;
  logic [6:0]  in_f7 = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [4:0]  in_rd = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [3:0]  out_addr;
  logic        out_illegal;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_addr = 0;
  int exp_err  = 0;

  instr_encoder #(.ADDR_W(4), .BASE_ADDR(0), .ERR_W(8)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_type     (in_type),
    .in_f3       (in_f3),
    .in_f7       (in_f7),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_rd       (in_rd),
    .in_imm      (in_imm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_addr    (out_addr),
    .out_illegal (out_illegal),
    .err_count   (err_count)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Reference encoder: field placement by shifts/masks, legality by numeric ranges
  function automatic void model(input logic [8:0] t,
                                input logic [31:0] f3, f7, rs1, rs2, rd, imm,
                                output logic [31:0] w, output logic ill);
    longint s;
    s   = longint'($signed(imm));
    w   = 32'h0;
    ill = 1'b0;
    if ($countones(t) > 1) ill = 1'b1;
    else case (t)
      9'h100: begin
        w   = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
        ill = !(f7 == 0 || f7 == 32) || (f7 == 32 && f3 != 0 && f3 != 5);
      end
      9'h080: begin
        if (f3 == 1 || f3 == 5) begin
          w   = (f7 << 25) | ((imm & 32'h1F) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
          ill = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 32);
        end else begin
          w   = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
          ill = (s < -2048) || (s > 2047);
        end
      end
      9'h040: begin
        w   = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h03;
        ill = (s < -2048) || (s > 2047) || f3 == 3 || f3 == 6 || f3 == 7;
      end
      9'h020: begin
        w   = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
            | ((imm & 32'h1F) << 7) | 32'h23;
        ill = (f3 > 2) || (s < -2048) || (s > 2047);
      end
      9'h010: begin
        w   = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
            | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
            | (((imm >> 11) & 1) << 7) | 32'h63;
        ill = f3 == 2 || f3 == 3 || imm[0] || (s < -4096) || (s > 4095);
      end
      9'h008: begin
        w   = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
            | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | 32'h6F;
        ill = imm[0] || (s < -1048576) || (s > 1048575);
      end
      9'h004: begin
        w   = (imm & 32'hFFFFF000) | (rd << 7) | 32'h37;
        ill = (imm & 32'hFFF) != 0;
      end
      9'h002: begin
        w   = (imm & 32'hFFFFF000) | (rd << 7) | 32'h17;
        ill = (imm & 32'hFFF) != 0;
      end
      9'h001: begin
        w   = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h67;
        ill = (s < -2048) || (s > 2047) || f3 != 0;
      end
      default: w = 32'h0;
    endcase
    if (ill) w = 32'h0;
  endfunction

  task automatic apply_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset_n   = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n  = 1'b1;
    exp_addr = 0;
    exp_err  = 0;
  endtask

  task automatic do_req(input logic [8:0] t, input logic [31:0] f3, f7, rs1, rs2, rd, imm,
                        input logic [31:0] ew, input logic eill, input int hold, input string nm);
    int          n;
    logic [31:0] s_instr;
    logic [3:0]  s_addr;
    logic        s_ill;
    logic        ok;
    @(negedge clock);
    n = 0;
    while (!in_ready && n < 8) begin
      @(negedge clock);
      n++;
    end
    check({nm, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_type   = t;
    in_f3     = f3[2:0];
    in_f7     = f7[6:0];
    in_rs1    = rs1[4:0];
    in_rs2    = rs2[4:0];
    in_rd     = rd[4:0];
    in_imm    = imm;
    out_ready = (hold == 0);
    @(posedge clock); #1;
    in_valid = 1'b0;
    in_type  = 9'($urandom);
    in_imm   = $urandom;
    in_f7    = 7'($urandom);
    check({nm, " enc_no_valid"}, 32'(out_valid), 32'd0);
    @(posedge clock); #1;
    if (eill && exp_err < 255) exp_err++;
    check({nm, " out_valid"}, 32'(out_valid), 32'd1);
    check({nm, " instr"}, out_instr, ew);
    check({nm, " illegal"}, 32'(out_illegal), 32'(eill));
    check({nm, " addr"}, 32'(out_addr), 32'(exp_addr));
    check({nm, " err_count"}, 32'(err_count), 32'(exp_err));
    if (hold > 0) begin
      s_instr = out_instr;
      s_addr  = out_addr;
      s_ill   = out_illegal;
      ok      = 1'b1;
      repeat (hold) begin
        @(posedge clock); #1;
        if (out_instr !== s_instr || out_addr !== s_addr || out_illegal !== s_ill ||
            in_ready !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
      end
      check({nm, " hold_stable"}, 32'(ok), 32'd1);
      out_ready = 1'b1;
    end
    @(posedge clock); #1;
    exp_addr = (exp_addr + 4) % 16;
    check({nm, " done_valid"}, 32'(out_valid), 32'd0);
    check({nm, " next_addr"}, 32'(out_addr), 32'(exp_addr));
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [8:0]  t;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] ew;
    logic        eill;
    int          hold;
    string       nm;
  } vec_t;

  vec_t tbl [18];

  initial begin
    logic [8:0]  t;
    logic [31:0] f3, f7, rs1, rs2, rd, imm, ew;
    logic        eill;

    tbl[0]  = '{9'h100, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'h0,        32'h002081B3, 1'b0, 0, "add"};
    tbl[1]  = '{9'h080, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'hFFFFFFFF, 32'hFFF00093, 1'b0, 0, "addi_m1"};
    tbl[2]  = '{9'h020, 3'd2, 7'h00, 5'd2, 5'd5, 5'd0, 32'h8,        32'h00512423, 1'b0, 0, "sw"};
    tbl[3]  = '{9'h010, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0, 5, "beq_bp"};
    tbl[4]  = '{9'h010, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'h3,        32'h00000000, 1'b1, 0, "beq_odd"};
    tbl[5]  = '{9'h100, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'h0,        32'h402081B3, 1'b0, 0, "sub"};
    tbl[6]  = '{9'h100, 3'd1, 7'h20, 5'd1, 5'd2, 5'd3, 32'h0,        32'h00000000, 1'b1, 0, "r_bad_f7"};
    tbl[7]  = '{9'h080, 3'd5, 7'h20, 5'd6, 5'd0, 5'd5, 32'h3,        32'h40335293, 1'b0, 2, "srai"};
    tbl[8]  = '{9'h080, 3'd1, 7'h20, 5'd6, 5'd0, 5'd5, 32'h3,        32'h00000000, 1'b1, 0, "slli_bad"};
    tbl[9]  = '{9'h040, 3'd2, 7'h00, 5'd2, 5'd0, 5'd5, 32'hFFFFFFF8, 32'hFF812283, 1'b0, 0, "lw"};
    tbl[10] = '{9'h040, 3'd3, 7'h00, 5'd2, 5'd0, 5'd5, 32'h0,        32'h00000000, 1'b1, 0, "load_f3"};
    tbl[11] = '{9'h004, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'h12345000, 32'h123450B7, 1'b0, 0, "lui"};
    tbl[12] = '{9'h004, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'h12345001, 32'h00000000, 1'b1, 0, "lui_low"};
    tbl[13] = '{9'h008, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'h8,        32'h008000EF, 1'b0, 0, "jal"};
    tbl[14] = '{9'h180, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'h0,        32'h00000000, 1'b1, 0, "multihot"};
    tbl[15] = '{9'h000, 3'd7, 7'h7F, 5'd1, 5'd2, 5'd3, 32'h5,        32'h00000000, 1'b0, 0, "nop"};
    tbl[16] = '{9'h080, 3'd0, 7'h00, 5'd1, 5'd0, 5'd1, 32'h800,      32'h00000000, 1'b1, 0, "addi_range"};
    tbl[17] = '{9'h001, 3'd1, 7'h00, 5'd1, 5'd0, 5'd1, 32'h0,        32'h00000000, 1'b1, 0, "jalr_f3"};

    apply_reset();
    #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_instr", out_instr, 32'h0);
    check("rst out_illegal", 32'(out_illegal), 32'd0);
    check("rst out_addr", 32'(out_addr), 32'd0);
    check("rst err_count", 32'(err_count), 32'd0);

    for (int i = 0; i < 18; i++)
      do_req(tbl[i].t, 32'(tbl[i].f3), 32'(tbl[i].f7), 32'(tbl[i].rs1), 32'(tbl[i].rs2),
             32'(tbl[i].rd), tbl[i].imm, tbl[i].ew, tbl[i].eill, tbl[i].hold, tbl[i].nm);

    // Address wrap from a fresh reset: 0, 4, 8, 12, 0
    apply_reset();
    for (int i = 0; i < 5; i++)
      do_req(9'h000, 0, 0, 0, 0, 0, 0, 32'h0, 1'b0, 0, $sformatf("wrap%0d", i));

    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 9))
        0:       t = 9'h000;
        1:       t = 9'($urandom) | 9'h003;
        default: t = 9'h001 << $urandom_range(0, 8);
      endcase
      f3  = $urandom_range(0, 7);
      case ($urandom_range(0, 2))
        0:       f7 = 32'h00;
        1:       f7 = 32'h20;
        default: f7 = $urandom_range(0, 127);
      endcase
      rs1 = $urandom_range(0, 31);
      rs2 = $urandom_range(0, 31);
      rd  = $urandom_range(0, 31);
      case ($urandom_range(0, 4))
        0:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        1:       imm = (32'($urandom_range(0, 8191)) - 32'd4096) & 32'hFFFFFFFE;
        2:       imm = $urandom;
        3:       imm = $urandom & 32'hFFFFF000;
        default: imm = 32'($urandom_range(0, 2097151)) - 32'd1048576;
      endcase
      model(t, f3, f7, rs1, rs2, rd, imm, ew, eill);
      do_req(t, f3, f7, rs1, rs2, rd, imm, ew, eill, ($urandom_range(0, 3) == 0) ? 3 : 0,
             $sformatf("rnd%0d", i));
    end

    // Reset while the request sits in ENC: nothing may come out
    @(negedge clock);
    in_valid = 1'b1;
    in_type  = 9'h100;
    in_f3    = 3'd0;
    in_f7    = 7'h00;
    @(posedge clock); #1;
    in_valid = 1'b0;
    check("enc_rst in_ready_before", 32'(in_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    check("enc_rst out_valid", 32'(out_valid), 32'd0);
    check("enc_rst in_ready", 32'(in_ready), 32'd1);
    check("enc_rst out_addr", 32'(out_addr), 32'd0);
    check("enc_rst err_count", 32'(err_count), 32'd0);
    @(posedge clock); #1;
    check("enc_rst no_partial", 32'(out_valid), 32'd0);
    @(negedge clock);
    reset_n  = 1'b1;
    exp_addr = 0;
    exp_err  = 0;

    // Drive the error counter into saturation
    for (int i = 0; i < 260; i++)
      do_req(9'h003, 0, 0, 0, 0, 0, 0, 32'h0, 1'b1, 0, $sformatf("sat%0d", i));
    check("sat final err_count", 32'(err_count), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
